data_bus_responder: RTL and testbench
=====================================

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, number of 32-bit data RAM words (power of two).
REQ-002 SHALL have parameter GPIO_W, default 8, width of GPIO ports (1..32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mem_addr  input  32  byte address from CPU memory stage.
REQ-006 mem_write  input  32  store data from CPU memory stage.
REQ-007 mem_wen  input  1  store enable; a load is implied every cycle mem_wen=0.
REQ-008 read_data  output  32  registered load data, feeds writeback stage.
REQ-009 gpio_in  input  GPIO_W  asynchronous external inputs.
REQ-010 gpio_out  output  GPIO_W  registered GPIO outputs.
REQ-011 timer_irq  output  1  level, equals STATUS.pending.
REQ-012 bad_addr  output  1  one-cycle registered pulse on access to unmapped address.

Function
REQ-013 Address decode SHALL use mem_addr[1:0] ignored (word access only).
REQ-014 Map: RAM at 0x0000_0000..(RAM_WORDS*4-1); GPIO_OUT 0x1000_0000 RW; GPIO_IN 0x1000_0004 RO; TIMER 0x1000_0008 RW; TIMER_CMP 0x1000_000C RW; STATUS 0x1000_0010 (bit0 pending, W1C); all else unmapped.
REQ-015 Read latency SHALL be exactly one cycle: read_data at edge N+1 reflects address presented in cycle N, regardless of mem_wen.
REQ-016 Same-cycle write and read of one location SHALL return the pre-write value (read-before-write).
REQ-017 Unmapped reads SHALL return 0; unmapped writes SHALL be ignored; bad_addr SHALL assert the following cycle for either.
REQ-018 Register reads SHALL zero-extend: GPIO_OUT/GPIO_IN upper bits and STATUS[31:1] read 0.
REQ-019 GPIO_IN SHALL be a two-flop synchronizer; read returns second-stage value.
REQ-020 TIMER SHALL increment by 1 every cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-021 Write to TIMER SHALL load mem_write, overriding that cycle's increment; next cycle it increments from the loaded value.
REQ-022 Read of TIMER SHALL return the value held during the access cycle (before that edge's increment).
REQ-023 When TIMER == TIMER_CMP in a cycle, pending SHALL be set at that edge.
REQ-024 Writing STATUS with bit0=1 SHALL clear pending; bit0=0 has no effect; set wins over simultaneous clear.
REQ-025 timer_irq SHALL be the registered pending bit, no combinational path from inputs.

Reset
REQ-026 On rst: read_data=0, gpio_out=0, TIMER=0, TIMER_CMP=0xFFFF_FFFF, pending=0, timer_irq=0, bad_addr=0, synchronizer flops=0.
REQ-027 RAM contents SHALL NOT be reset; reads of unwritten RAM are undefined.
REQ-028 Reset asserted mid-access SHALL discard that access; no write occurs in a cycle where rst is high.

Structure
REQ-029 Address constants (base addresses, register offsets, STATUS bit index) SHALL live in shared package/include dbus_map, reused by CPU test programs.
REQ-030 Timer/compare/pending logic SHALL be sub-module io_timer; RAM and decode stay in the top.
REQ-031 RAM SHALL be inferable as synchronous single-port block RAM (registered read).

Verification
REQ-032 Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> read_data=0xDEADBEEF one cycle after the read; read 0x0000_0013 -> same value.
REQ-033 Write 0x0000_00A5 to GPIO_OUT -> gpio_out=0xA5 next cycle; drive gpio_in=0x3C, read GPIO_IN two cycles later -> 0x0000_003C.
REQ-034 Write TIMER=0xFFFF_FFFE, TIMER_CMP=0x0000_0001 -> TIMER wraps to 0, timer_irq=1 the edge TIMER==1; write STATUS=1 -> timer_irq=0 next cycle.
REQ-035 Write STATUS=1 in the same cycle TIMER==TIMER_CMP -> timer_irq remains 1.
REQ-036 Read 0x2000_0000, write 0x1000_0014 -> read_data=0, bad_addr pulses 1 cycle each, no register changes.
REQ-037 Assert rst while timer_irq=1 and gpio_out=0xFF -> all outputs 0 immediately, TIMER_CMP reads 0xFFFF_FFFF after release.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// Shared address map for the data bus responder.
// Holds base addresses, register offsets, the STATUS pending bit index and
// the decode-target enum. CPU test programs import the same constants so
// software and hardware agree on the memory map.
package dbus_map;

  localparam logic [31:0] RAM_BASE           = 32'h0000_0000;
  localparam logic [31:0] IO_BASE            = 32'h1000_0000;

  localparam logic [31:0] GPIO_OUT_OFS       = 32'h0000_0000;
  localparam logic [31:0] GPIO_IN_OFS        = 32'h0000_0004;
  localparam logic [31:0] TIMER_OFS          = 32'h0000_0008;
  localparam logic [31:0] TIMER_CMP_OFS      = 32'h0000_000C;
  localparam logic [31:0] STATUS_OFS         = 32'h0000_0010;

  localparam logic [31:0] ADDR_GPIO_OUT      = IO_BASE + GPIO_OUT_OFS;
  localparam logic [31:0] ADDR_GPIO_IN       = IO_BASE + GPIO_IN_OFS;
  localparam logic [31:0] ADDR_TIMER         = IO_BASE + TIMER_OFS;
  localparam logic [31:0] ADDR_TIMER_CMP     = IO_BASE + TIMER_CMP_OFS;
  localparam logic [31:0] ADDR_STATUS        = IO_BASE + STATUS_OFS;

  localparam int          STATUS_PENDING_BIT = 0;

  localparam logic [31:0] TIMER_CMP_RESET    = 32'hFFFF_FFFF;

  // Which target a bus address decodes to.
  typedef enum logic [2:0] {
    SEL_NONE      = 3'd0,
    SEL_RAM       = 3'd1,
    SEL_GPIO_OUT  = 3'd2,
    SEL_GPIO_IN   = 3'd3,
    SEL_TIMER     = 3'd4,
    SEL_TIMER_CMP = 3'd5,
    SEL_STATUS    = 3'd6
  } dbus_sel_e;

  // Word-granular compare: the two byte-offset bits never take part in decode.
  function automatic logic word_match(input logic [31:0] addr, input logic [31:0] target);
    return (addr[31:2] == target[31:2]);
  endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// CPU memory-stage bus bundle.
//   mem_addr  : byte address (word access only)
//   mem_write : store data
//   mem_wen   : store enable; every cycle with mem_wen=0 is a load
//   read_data : load data, valid one cycle after the address
// master = CPU side, slave = responder side.
interface data_bus_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_write;
  logic        mem_wen;
  logic [31:0] read_data;

  modport master (output mem_addr, output mem_write, output mem_wen, input read_data);
  modport slave  (input mem_addr, input mem_write, input mem_wen, output read_data);
endinterface

// File: rtl/data_bus_responder_io_timer.sv
// Free-running 32-bit timer with compare register and sticky pending flag.
// Ports:
//   clk, rst      : clock, async active-high reset
//   timer_we_i    : load TIMER from wdata_i (overrides this cycle's increment)
//   cmp_we_i      : load TIMER_CMP from wdata_i
//   status_we_i   : STATUS write; bit0=1 clears pending
//   wdata_i       : store data
//   timer_o       : current TIMER value
//   cmp_o         : current TIMER_CMP value
//   pending_o     : registered pending flag (drives timer_irq)
module io_timer
  import dbus_map::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_we_i,
  input  logic        cmp_we_i,
  input  logic        status_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] timer_o,
  output logic [31:0] cmp_o,
  output logic        pending_o
);

  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q, cmp_d;
  logic        pending_q, pending_d;
  logic        hit_s;

  assign hit_s = (timer_q == cmp_q);

  // Next-state for timer, compare and pending; a compare hit beats a W1C clear.
  always_comb begin
    timer_d   = timer_q + 32'd1;
    cmp_d     = cmp_q;
    pending_d = pending_q;
    if (timer_we_i) begin
      timer_d = wdata_i;
    end else begin
      timer_d = timer_q + 32'd1;
    end
    if (cmp_we_i) begin
      cmp_d = wdata_i;
    end else begin
      cmp_d = cmp_q;
    end
    if (hit_s) begin
      pending_d = 1'b1;
    end else if (status_we_i && wdata_i[STATUS_PENDING_BIT]) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q   <= 32'h0000_0000;
      cmp_q     <= TIMER_CMP_RESET;
      pending_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      pending_q <= pending_d;
    end
  end

  assign timer_o   = timer_q;
  assign cmp_o     = cmp_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory responder for a simple CPU: word RAM plus GPIO and timer
// registers behind a one-cycle-latency load/store bus.
// Ports:
//   clk, rst   : clock, async active-high reset
//   bus        : slave side of the CPU memory-stage bus
//   gpio_in    : asynchronous external inputs (two-flop synchronised)
//   gpio_out   : registered GPIO outputs
//   timer_irq  : registered timer pending flag
//   bad_addr   : one-cycle pulse after any access to an unmapped address
module data_bus_responder
  import dbus_map::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int GPIO_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  data_bus_responder_if.slave  bus,
  input  logic [GPIO_W-1:0]    gpio_in,
  output logic [GPIO_W-1:0]    gpio_out,
  output logic                 timer_irq,
  output logic                 bad_addr
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  dbus_sel_e          sel_s;
  logic               wen_s;
  logic [RAM_AW-1:0]  ram_idx_s;
  logic [31:0]        reg_rd_d, reg_rd_q;
  logic               ram_sel_q;
  logic [31:0]        ram_rd_q;
  logic [31:0]        ram_q [RAM_WORDS];
  logic [GPIO_W-1:0]  gpio_out_q;
  logic [GPIO_W-1:0]  sync1_q, sync2_q;
  logic               bad_addr_q;
  logic [31:0]        timer_s, cmp_s;
  logic               pending_s;
  logic [1:0]         unused_addr_s;

  assign unused_addr_s = bus.mem_addr[1:0];
  assign ram_idx_s     = bus.mem_addr[RAM_AW+1:2];
  // A write is never committed while reset is held.
  assign wen_s         = bus.mem_wen & ~rst;

  // Address decode to a single target.
  always_comb begin
    sel_s = SEL_NONE;
    if (bus.mem_addr[31:2] < 30'(RAM_WORDS)) begin
      sel_s = SEL_RAM;
    end else if (word_match(bus.mem_addr, ADDR_GPIO_OUT)) begin
      sel_s = SEL_GPIO_OUT;
    end else if (word_match(bus.mem_addr, ADDR_GPIO_IN)) begin
      sel_s = SEL_GPIO_IN;
    end else if (word_match(bus.mem_addr, ADDR_TIMER)) begin
      sel_s = SEL_TIMER;
    end else if (word_match(bus.mem_addr, ADDR_TIMER_CMP)) begin
      sel_s = SEL_TIMER_CMP;
    end else if (word_match(bus.mem_addr, ADDR_STATUS)) begin
      sel_s = SEL_STATUS;
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // Register read mux; sampled from pre-edge values so a same-cycle write
  // returns the old contents. RAM and unmapped reads leave this at zero.
  always_comb begin
    reg_rd_d = 32'h0000_0000;
    case (sel_s)
      SEL_GPIO_OUT:  reg_rd_d = 32'(gpio_out_q);
      SEL_GPIO_IN:   reg_rd_d = 32'(sync2_q);
      SEL_TIMER:     reg_rd_d = timer_s;
      SEL_TIMER_CMP: reg_rd_d = cmp_s;
      SEL_STATUS:    reg_rd_d = {31'h0000_0000, pending_s};
      default:       reg_rd_d = 32'h0000_0000;
    endcase
  end

  // Single-port RAM with registered read-first output (no reset, block-RAM friendly).
  always_ff @(posedge clk) begin
    if (wen_s && (sel_s == SEL_RAM)) begin
      ram_q[ram_idx_s] <= bus.mem_write;
    end
    ram_rd_q <= ram_q[ram_idx_s];
  end

  // Read path select, GPIO, synchroniser and bad-address pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_rd_q   <= 32'h0000_0000;
      ram_sel_q  <= 1'b0;
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      bad_addr_q <= 1'b0;
    end else begin
      reg_rd_q   <= reg_rd_d;
      ram_sel_q  <= (sel_s == SEL_RAM);
      if (wen_s && (sel_s == SEL_GPIO_OUT)) begin
        gpio_out_q <= bus.mem_write[GPIO_W-1:0];
      end
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
      bad_addr_q <= (sel_s == SEL_NONE);
    end
  end

  io_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .timer_we_i  (wen_s && (sel_s == SEL_TIMER)),
    .cmp_we_i    (wen_s && (sel_s == SEL_TIMER_CMP)),
    .status_we_i (wen_s && (sel_s == SEL_STATUS)),
    .wdata_i     (bus.mem_write),
    .timer_o     (timer_s),
    .cmp_o       (cmp_s),
    .pending_o   (pending_s)
  );

  // Both read sources are flops; the select flop resets to the zeroed register path.
  assign bus.read_data = ram_sel_q ? ram_rd_q : reg_rd_q;
  assign gpio_out      = gpio_out_q;
  assign timer_irq     = pending_s;
  assign bad_addr      = bad_addr_q;

endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;

  logic       clk;
  logic       rst;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic       timer_irq;
  logic       bad_addr;

  data_bus_responder_if bus_if ();

  data_bus_responder #(.RAM_WORDS(256), .GPIO_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq),
    .bad_addr  (bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_bad;
    logic [7:0]  exp_gpio;
  } vec_t;

  vec_t vecs [24];
  int   pass_cnt;
  int   total_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, clock, sample 1 time unit after the edge.
  task automatic cyc(input logic [31:0] addr, input logic [31:0] wdata, input logic wen);
    bus_if.mem_addr  = addr;
    bus_if.mem_write = wdata;
    bus_if.mem_wen   = wen;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] A_GOUT = 32'h1000_0000;
  localparam logic [31:0] A_GIN  = 32'h1000_0004;
  localparam logic [31:0] A_TMR  = 32'h1000_0008;
  localparam logic [31:0] A_CMP  = 32'h1000_000C;
  localparam logic [31:0] A_STAT = 32'h1000_0010;

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;

    vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,         1'b0, 8'h00};
    vecs[1]  = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00};
    vecs[2]  = '{32'h0000_0013, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00};
    vecs[3]  = '{32'h0000_0014, 32'h1234_5678, 1'b1, 1'b0, 32'h0,         1'b0, 8'h00};
    vecs[4]  = '{32'h0000_0014, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 8'h00};
    vecs[5]  = '{32'h0000_0014, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 8'h00};
    vecs[6]  = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00};
    vecs[7]  = '{32'h0000_03FC, 32'h1111_1111, 1'b1, 1'b0, 32'h0,         1'b0, 8'h00};
    vecs[8]  = '{32'h0000_03FC, 32'h0,         1'b0, 1'b1, 32'h1111_1111, 1'b0, 8'h00};
    vecs[9]  = '{A_GOUT,        32'h0000_00A5, 1'b1, 1'b1, 32'h0,         1'b0, 8'hA5};
    vecs[10] = '{A_GOUT,        32'h0,         1'b0, 1'b1, 32'h0000_00A5, 1'b0, 8'hA5};
    vecs[11] = '{A_GOUT,        32'h0000_01FF, 1'b1, 1'b1, 32'h0000_00A5, 1'b0, 8'hFF};
    vecs[12] = '{A_GOUT,        32'h0,         1'b0, 1'b1, 32'h0000_00FF, 1'b0, 8'hFF};
    vecs[13] = '{A_CMP,         32'h0,         1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 8'hFF};
    vecs[14] = '{A_CMP,         32'h0001_2345, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 8'hFF};
    vecs[15] = '{A_CMP,         32'h0,         1'b0, 1'b1, 32'h0001_2345, 1'b0, 8'hFF};
    vecs[16] = '{32'h2000_0000, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 8'hFF};
    vecs[17] = '{32'h1000_0014, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0,         1'b1, 8'hFF};
    vecs[18] = '{32'h0000_0400, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 8'hFF};
    vecs[19] = '{A_STAT,        32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 8'hFF};
    vecs[20] = '{A_GIN,         32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 8'hFF};
    vecs[21] = '{32'h1000_0003, 32'h0,         1'b0, 1'b1, 32'h0000_00FF, 1'b0, 8'hFF};
    vecs[22] = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'hFF};
    vecs[23] = '{32'h1000_0018, 32'h0000_0055, 1'b1, 1'b1, 32'h0,         1'b1, 8'hFF};

    // Reset state
    rst = 1'b1;
    gpio_in = 8'h00;
    bus_if.mem_addr  = 32'h0;
    bus_if.mem_write = 32'h0;
    bus_if.mem_wen   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_read_data", bus_if.read_data, 32'h0);
    chk("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
    chk("rst_timer_irq", {31'h0, timer_irq}, 32'h0);
    chk("rst_bad_addr", {31'h0, bad_addr}, 32'h0);
    rst = 1'b0;
    cyc(A_TMR, 32'h0, 1'b0);
    chk("timer_after_rst", bus_if.read_data, 32'h0);

    // Table-driven vectors
    for (int i = 0; i < 24; i++) begin
      cyc(vecs[i].addr, vecs[i].wdata, vecs[i].wen);
      if (vecs[i].chk_rd) begin
        chk($sformatf("vec%0d_rd", i), bus_if.read_data, vecs[i].exp_rd);
      end
      chk($sformatf("vec%0d_bad", i), {31'h0, bad_addr}, {31'h0, vecs[i].exp_bad});
      chk($sformatf("vec%0d_gpio", i), {24'h0, gpio_out}, {24'h0, vecs[i].exp_gpio});
    end

    // GPIO_IN passes through two flops before it is readable
    gpio_in = 8'h3C;
    cyc(A_GIN, 32'h0, 1'b0);
    chk("gin_early1", bus_if.read_data, 32'h0);
    cyc(A_GIN, 32'h0, 1'b0);
    chk("gin_early2", bus_if.read_data, 32'h0);
    cyc(A_GIN, 32'h0, 1'b0);
    chk("gin_sync", bus_if.read_data, 32'h0000_003C);

    // Timer wrap and compare at 1, then W1C clear
    cyc(A_CMP, 32'h0000_0001, 1'b1);
    cyc(A_TMR, 32'hFFFF_FFFE, 1'b1);
    cyc(A_TMR, 32'h0, 1'b0);
    chk("tmr_fffe", bus_if.read_data, 32'hFFFF_FFFE);
    cyc(A_TMR, 32'h0, 1'b0);
    chk("tmr_ffff", bus_if.read_data, 32'hFFFF_FFFF);
    cyc(A_TMR, 32'h0, 1'b0);
    chk("tmr_wrap0", bus_if.read_data, 32'h0);
    chk("irq_before_hit", {31'h0, timer_irq}, 32'h0);
    cyc(A_TMR, 32'h0, 1'b0);
    chk("tmr_one", bus_if.read_data, 32'h1);
    chk("irq_at_hit", {31'h0, timer_irq}, 32'h1);
    cyc(A_STAT, 32'h0, 1'b0);
    chk("status_pending", bus_if.read_data, 32'h1);
    cyc(A_STAT, 32'h1, 1'b1);
    chk("irq_cleared", {31'h0, timer_irq}, 32'h0);
    cyc(A_STAT, 32'h0, 1'b0);
    chk("status_clear_rd", bus_if.read_data, 32'h0);

    // Clear coinciding with a compare hit: set wins
    cyc(A_CMP, 32'h0000_0102, 1'b1);
    cyc(A_TMR, 32'h0000_0100, 1'b1);
    cyc(A_TMR, 32'h0, 1'b0);
    chk("tmr_load", bus_if.read_data, 32'h0000_0100);
    cyc(A_TMR, 32'h0, 1'b0);
    chk("tmr_load_inc", bus_if.read_data, 32'h0000_0101);
    chk("irq_pre_tie", {31'h0, timer_irq}, 32'h0);
    cyc(A_STAT, 32'h1, 1'b1);
    chk("irq_set_wins", {31'h0, timer_irq}, 32'h1);
    cyc(A_STAT, 32'h0, 1'b1);
    chk("irq_w0_noeffect", {31'h0, timer_irq}, 32'h1);
    chk("status_w0_rd", bus_if.read_data, 32'h1);
    cyc(32'h2000_0000, 32'h0, 1'b0);
    chk("bad_pre_rst", {31'h0, bad_addr}, 32'h1);

    // Reset mid-access: outputs drop immediately, the pending store is discarded
    bus_if.mem_addr  = 32'h0000_0010;
    bus_if.mem_write = 32'h5555_5555;
    bus_if.mem_wen   = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_read_data", bus_if.read_data, 32'h0);
    chk("arst_gpio_out", {24'h0, gpio_out}, 32'h0);
    chk("arst_timer_irq", {31'h0, timer_irq}, 32'h0);
    chk("arst_bad_addr", {31'h0, bad_addr}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(A_CMP, 32'h0, 1'b0);
    chk("cmp_after_rst", bus_if.read_data, 32'hFFFF_FFFF);
    cyc(32'h0000_0010, 32'h0, 1'b0);
    chk("ram_no_write_in_rst", bus_if.read_data, 32'hDEAD_BEEF);
    cyc(A_TMR, 32'h0, 1'b0);
    chk("timer_restart", bus_if.read_data, 32'h2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
